serial_rx: RTL
==============

# serial_rx

Serial frame receiver; the downstream counterpart of `serial_com`. Samples an LSB-first single-bit stream, hunts for the SOF marker, deserializes 32-bit payload words and writes them into the receive-side FIFO as 33-bit entries. Bit 32 of each entry flags the last word of a frame, which is the same `{eof, data}` format `serial_com` reads on its side. Sits between the serial link and the FIFO write port.

## Interface
- `SOF_WORD`, default 32'h5a5a5a5a: start-of-frame marker.
- `EOF_WORD`, default 32'h0f0f0f0f: end-of-frame marker.
- `CNT_W`, default 16: width of the statistics counters.

- `wclk`  in  1  clock; one serial bit is sampled per rising edge.
- `wrst_n`  in  1  reset; asynchronous, active-low.
- `s_in`  in  1  serial data, LSB of each word first; idle level 0.
- `wfull`  in  1  FIFO full flag.
- `winc`  out  1  FIFO write strobe, one cycle per entry.
- `wdata`  out  33  FIFO write data: `{eof, word[31:0]}`.
- `in_frame`  out  1  high while in DATA state.
- `ovf`  out  1  sticky overflow flag: a word was dropped because `wfull` was high.
- `pkt_cnt`  out  CNT_W  completed frames, saturating.
- `drop_cnt`  out  CNT_W  dropped words, saturating.
- `empty_cnt`  out  CNT_W  frames with zero payload words, saturating.

## Operation
- Shift window `sr[31:0]` updates every edge: `sr <= {s_in, sr[31:1]}`. `nsr` is the post-shift value, evaluated combinationally.
- Bit counter `bc[4:0]` is active only in DATA.
- Word register `hold[31:0]` with valid flag `hv`.
- **HUNT** (reset state)
  - If `nsr == SOF_WORD`: go to DATA, set `bc <= 0`, clear `hv`.
  - No other action. Leading garbage, idle zeros and post-EOF tail bits are ignored, and any bit alignment is acceptable.
- **DATA**
  - `bc` increments every edge and wraps 31 -> 0.
  - The edge with `bc == 31` is a word boundary and `w = nsr`.
  - If `w == EOF_WORD` and `hv`: write `{1'b1, hold}`, increment `pkt_cnt`, go to HUNT.
  - If `w == EOF_WORD` and not `hv`: no write, increment `empty_cnt`, go to HUNT.
  - Otherwise, if `hv`, write `{1'b0, hold}`. In all non-EOF cases `hold <= w` and `hv <= 1`.
- The one-word hold delay exists because the last data word is identified only when the EOF marker follows it.
- A payload word equal to EOF_WORD terminates the frame. Upstream must not send it; this is a protocol restriction, not a block error.
- **Write attempt**
  - If `wfull == 0`: `winc <= 1`, `wdata <=` entry.
  - If `wfull == 1`: `winc <= 0`, the entry is discarded, `ovf <= 1`, `drop_cnt` increments.
  - There is no retry and no backpressure on the serial side.
  - A dropped eof entry still counts in `pkt_cnt`.
- `wdata` holds its last written value when `winc == 0`.
- Counters saturate at all-ones. `ovf` clears only on reset.

## Timing
- **Reset values:** all of the following are zero: `winc`, `wdata`, `in_frame`, `ovf`, `pkt_cnt`, `drop_cnt`, `empty_cnt`, `sr`, `bc`, `hv`. State is HUNT. Reset takes effect immediately and asynchronously.
- **SOF detection:** the edge sampling the 32nd SOF bit moves to DATA. `in_frame` is high from the following cycle.
- **Write latency:** `winc`/`wdata` are registered on the edge sampling bit 31 of the *following* word, or of the EOF marker. `winc` is high for exactly that one cycle, and writes are at least 32 cycles apart.
- `wfull` is sampled on that same edge.
- **End of frame:** `in_frame` falls the cycle after the edge that completes the EOF marker. HUNT is active from the next edge.
- **Back-to-back frames:** a tail of 16 or more bits, or no gap at all, between EOF and the next SOF is supported. SOF can be detected as early as 32 edges after EOF completion.
- **Reset mid-frame:** `hold` is discarded and no eof entry is written. Entries already in the FIFO stay there without eof; downstream treats a reset as frame abort.

## Test plan
- **Idle:** hold `s_in = 0` for 200 cycles -> `winc` never high, `in_frame = 0`, all counters 0.
- **Basic frame:** 7 random bits, then SOF, 0x11111111, 0x22222222, 0x33333333, EOF, 16-bit 0x0f0f tail -> writes 0x0_11111111, 0x0_22222222, 0x1_33333333.
  - Each `winc` lands one cycle after the last bit of the next word.
  - `pkt_cnt = 1`.
- **Empty frame:** SOF immediately followed by EOF -> no `winc`, `empty_cnt = 1`, `pkt_cnt = 0`, back in HUNT.
- **Overflow:** same frame as the basic case, with `wfull = 1` only on the cycle of the second write -> 0x0_22222222 dropped, `ovf = 1`, `drop_cnt = 1`, other two entries written.
- **Reset mid-frame:** assert `wrst_n = 0` mid-word after two data words -> all outputs 0 immediately. A following full frame is received exactly as in the basic case.
- **Stress:** 50 back-to-back frames of 1 to 20 random words (excluding EOF_WORD) with random gaps 0 to 40 bits -> every word delivered in order, eof set only on the last word of each frame, `pkt_cnt = 50`.

Source files
------------

// File: rtl/serial_rx_if.sv
// FIFO write-side bundle between serial_rx (master) and the receive FIFO (slave).
// Entries are {eof, data[31:0]}.
interface serial_rx_if;
    logic        winc;
    logic [32:0] wdata;
    logic        wfull;

    modport master (output winc, output wdata, input wfull);
    modport slave  (input winc, input wdata, output wfull);
endinterface

// File: rtl/serial_rx.sv
// Serial frame receiver: hunts for SOF in an LSB-first bit stream, deserializes 32-bit words
// and writes {eof, word} entries into the receive FIFO, one word behind the stream.
module serial_rx #(
    parameter logic [31:0] SOF_WORD = 32'h5a5a5a5a,
    parameter logic [31:0] EOF_WORD = 32'h0f0f0f0f,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             s_in,
    serial_rx_if.master      fifo,
    output logic             in_frame,
    output logic             ovf,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] empty_cnt
);

    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_DATA = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]       r_state;
    logic [31:0]      r_sr;
    logic [4:0]       r_bc;
    logic [31:0]      r_hold;
    logic             r_hv;
    logic             r_winc;
    logic [32:0]      r_wdata;
    logic             r_ovf;
    logic [CNT_W-1:0] r_pkt_cnt;
    logic [CNT_W-1:0] r_drop_cnt;
    logic [CNT_W-1:0] r_empty_cnt;

    logic [31:0]      w_nsr;
    logic             w_boundary;
    logic             w_is_eof;
    logic             w_wr_req;
    logic [32:0]      w_entry;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    always_comb begin
        w_nsr      = {s_in, r_sr[31:1]};
        w_boundary = (r_state == ST_DATA) && (r_bc == 5'd31);
        w_is_eof   = (w_nsr == EOF_WORD);
        // The held word is written only once the next word reveals whether it was the last.
        w_wr_req   = w_boundary && r_hv;
        w_entry    = {w_is_eof, r_hold};
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state     <= ST_HUNT;
            r_sr        <= '0;
            r_bc        <= '0;
            r_hold      <= '0;
            r_hv        <= 1'b0;
            r_winc      <= 1'b0;
            r_wdata     <= '0;
            r_ovf       <= 1'b0;
            r_pkt_cnt   <= '0;
            r_drop_cnt  <= '0;
            r_empty_cnt <= '0;
        end else begin
            r_sr   <= w_nsr;
            r_winc <= 1'b0;

            if (w_wr_req) begin
                if (!fifo.wfull) begin
                    r_winc  <= 1'b1;
                    r_wdata <= w_entry;
                end else begin
                    r_ovf      <= 1'b1;
                    r_drop_cnt <= sat_inc(r_drop_cnt);
                end
            end

            case (r_state)
                ST_HUNT: begin
                    if (w_nsr == SOF_WORD) begin
                        r_state <= ST_DATA;
                        r_bc    <= '0;
                        r_hv    <= 1'b0;
                    end
                end
                default: begin
                    r_bc <= r_bc + 5'd1;
                    if (w_boundary) begin
                        if (w_is_eof) begin
                            r_state <= ST_HUNT;
                            if (r_hv) r_pkt_cnt   <= sat_inc(r_pkt_cnt);
                            else      r_empty_cnt <= sat_inc(r_empty_cnt);
                        end else begin
                            r_hold <= w_nsr;
                            r_hv   <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign fifo.winc  = r_winc;
    assign fifo.wdata = r_wdata;
    assign in_frame   = (r_state == ST_DATA);
    assign ovf        = r_ovf;
    assign pkt_cnt    = r_pkt_cnt;
    assign drop_cnt   = r_drop_cnt;
    assign empty_cnt  = r_empty_cnt;

endmodule
